// File: rtl/cluster_seq_pkg.sv
// Shared types for the cluster clock/reset sequencer: FSM state, request priority, timer width.
package cluster_seq_pkg;

  localparam int unsigned SEQ_CNT_W = 8;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    RAMP_UP   = 3'd1,
    RST_HOLD  = 3'd2,
    RUN       = 3'd3,
    WARM_RST  = 3'd4,
    DBG_INIT  = 3'd5,
    SHUT_HOLD = 3'd6,
    RAMP_DN   = 3'd7
  } seq_state_t;

  // Higher encoding wins when several RUN requests arrive together.
  typedef enum logic [1:0] {
    REQ_NONE = 2'd0,
    REQ_DBG  = 2'd1,
    REQ_WARM = 2'd2,
    REQ_SHUT = 2'd3
  } req_t;

  function automatic req_t pick_req(input logic shut, input logic warm, input logic dbg);
    if (shut) return REQ_SHUT;
    if (warm) return REQ_WARM;
    if (dbg)  return REQ_DBG;
    return REQ_NONE;
  endfunction

endpackage

// File: rtl/cluster_clkrst_seq_if.sv
// Request/status bundle between the chip controller (master) and the clock/reset sequencer (slave).
interface cluster_clkrst_seq_if #(
  parameter int unsigned N = 4
);
  logic         pwr_on_req;
  logic         shutdown_req;
  logic         warm_rst_req;
  logic         dbg_req;
  logic [N-1:0] cluster_mask;
  logic [N-1:0] cluster_cken;
  logic         grst_l;
  logic         gdbginit_l;
  logic         seq_busy;
  logic         seq_done;

  modport master (
    output pwr_on_req, shutdown_req, warm_rst_req, dbg_req, cluster_mask,
    input  cluster_cken, grst_l, gdbginit_l, seq_busy, seq_done
  );

  modport slave (
    input  pwr_on_req, shutdown_req, warm_rst_req, dbg_req, cluster_mask,
    output cluster_cken, grst_l, gdbginit_l, seq_busy, seq_done
  );
endinterface

// File: rtl/cluster_seq_timer.sv
// Loadable down-counter that saturates at zero; times stagger and hold intervals.
module cluster_seq_timer
  import cluster_seq_pkg::*;
#(
  parameter int unsigned CNT_W = SEQ_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             zero_c
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  assign zero_c = (cnt == '0);

endmodule

// File: rtl/cluster_clkrst_seq.sv
// Chip-level cluster clock/reset sequencer: staggered clock ramp, global reset/debug-init episodes, shutdown.
// Build option: define CLUSTER_SEQ_DBGINIT_EN to enable the debug-init episode.
module cluster_clkrst_seq
  import cluster_seq_pkg::*;
#(
  parameter int unsigned NUM_CLUSTERS = 4,
  parameter int unsigned STAGGER_CYC  = 4,
  parameter int unsigned RST_HOLD_CYC = 16,
  parameter int unsigned CNT_W        = SEQ_CNT_W
) (
  input  logic                gclk,
  input  logic                rst,
  cluster_clkrst_seq_if.slave bus
);

  localparam int unsigned SLOT_W = (NUM_CLUSTERS > 1) ? $clog2(NUM_CLUSTERS) : 1;
  localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(NUM_CLUSTERS - 1);
  localparam logic [CNT_W-1:0]  STG_LD    = CNT_W'(STAGGER_CYC - 1);
  localparam logic [CNT_W-1:0]  HOLD_LD   = CNT_W'(RST_HOLD_CYC - 1);
  // Shutdown spends one cycle before dropping grst_l and one cycle handing over to RAMP_DN.
  localparam logic [CNT_W-1:0]  SHUT_LD   = CNT_W'(RST_HOLD_CYC - 2);

`ifdef CLUSTER_SEQ_DBGINIT_EN
  localparam logic WARM_DBG_L = 1'b1;
  logic dbg_c;
  assign dbg_c = bus.dbg_req;
`else
  // Without the debug-init episode gdbginit_l tracks grst_l and dbg_req is ignored.
  localparam logic WARM_DBG_L = 1'b0;
  logic dbg_c;
  assign dbg_c = 1'b0 & bus.dbg_req;
`endif

  seq_state_t              state;
  logic [SLOT_W-1:0]       slot;
  logic                    fin;
  logic [NUM_CLUSTERS-1:0] mask_q;
  logic [NUM_CLUSTERS-1:0] cken_q;
  logic                    grst_q;
  logic                    gdbg_q;
  logic                    busy_q;
  logic                    done_q;

  logic                    tmr_load_c;
  logic [CNT_W-1:0]        tmr_val_c;
  logic                    tmr_zero_c;
  req_t                    req_c;

  assign req_c = pick_req(bus.shutdown_req, bus.warm_rst_req, dbg_c);

  cluster_seq_timer #(.CNT_W(CNT_W)) u_timer (
    .clk      (gclk),
    .rst      (rst),
    .load     (tmr_load_c),
    .load_val (tmr_val_c),
    .zero_c   (tmr_zero_c)
  );

  // Timer reloads: every interval ends on zero, so IDLE and RUN always see an idle timer.
  always_comb begin
    tmr_load_c = 1'b0;
    tmr_val_c  = '0;
    case (state)
      RAMP_UP: begin
        if (tmr_zero_c) begin
          tmr_load_c = 1'b1;
          tmr_val_c  = fin ? HOLD_LD : STG_LD;
        end
      end
      RAMP_DN: begin
        if (tmr_zero_c && !fin) begin
          tmr_load_c = 1'b1;
          tmr_val_c  = STG_LD;
        end
      end
      SHUT_HOLD: begin
        if (tmr_zero_c && !fin) begin
          tmr_load_c = 1'b1;
          tmr_val_c  = SHUT_LD;
        end
      end
      RUN: begin
        if (req_c == REQ_WARM || req_c == REQ_DBG) begin
          tmr_load_c = 1'b1;
          tmr_val_c  = HOLD_LD;
        end
      end
      default: ;
    endcase
  end

  // Sequencer FSM with registered outputs; fin marks "last slot done" for ramps and "reset dropped" for shutdown.
  always_ff @(posedge gclk) begin
    if (rst) begin
      state  <= IDLE;
      slot   <= '0;
      fin    <= 1'b0;
      mask_q <= '0;
      cken_q <= '0;
      grst_q <= 1'b0;
      gdbg_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.pwr_on_req) begin
            mask_q <= bus.cluster_mask;
            slot   <= '0;
            fin    <= 1'b0;
            busy_q <= 1'b1;
            state  <= RAMP_UP;
          end
        end
        RAMP_UP: begin
          if (tmr_zero_c) begin
            if (fin) begin
              fin   <= 1'b0;
              state <= RST_HOLD;
            end else begin
              cken_q[slot] <= mask_q[slot];
              if (slot == LAST_SLOT) fin <= 1'b1;
              else                   slot <= slot + SLOT_W'(1);
            end
          end
        end
        RST_HOLD, WARM_RST: begin
          if (tmr_zero_c) begin
            grst_q <= 1'b1;
            gdbg_q <= 1'b1;
            busy_q <= 1'b0;
            done_q <= 1'b1;
            state  <= RUN;
          end
        end
`ifdef CLUSTER_SEQ_DBGINIT_EN
        DBG_INIT: begin
          if (tmr_zero_c) begin
            gdbg_q <= 1'b1;
            busy_q <= 1'b0;
            done_q <= 1'b1;
            state  <= RUN;
          end
        end
`endif
        RUN: begin
          case (req_c)
            REQ_SHUT: begin
              fin    <= 1'b0;
              busy_q <= 1'b1;
              done_q <= 1'b0;
              state  <= SHUT_HOLD;
            end
            REQ_WARM: begin
              grst_q <= 1'b0;
              gdbg_q <= WARM_DBG_L;
              busy_q <= 1'b1;
              done_q <= 1'b0;
              state  <= WARM_RST;
            end
`ifdef CLUSTER_SEQ_DBGINIT_EN
            REQ_DBG: begin
              gdbg_q <= 1'b0;
              busy_q <= 1'b1;
              done_q <= 1'b0;
              state  <= DBG_INIT;
            end
`endif
            default: ;
          endcase
        end
        SHUT_HOLD: begin
          if (tmr_zero_c) begin
            if (fin) begin
              fin   <= 1'b0;
              slot  <= LAST_SLOT;
              state <= RAMP_DN;
            end else begin
              grst_q <= 1'b0;
              gdbg_q <= 1'b0;
              fin    <= 1'b1;
            end
          end
        end
        RAMP_DN: begin
          if (tmr_zero_c) begin
            if (fin) begin
              fin    <= 1'b0;
              busy_q <= 1'b0;
              state  <= IDLE;
            end else begin
              cken_q[slot] <= 1'b0;
              if (slot == '0) fin <= 1'b1;
              else            slot <= slot - SLOT_W'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.cluster_cken = cken_q;
  assign bus.grst_l       = grst_q;
  assign bus.gdbginit_l   = gdbg_q;
  assign bus.seq_busy     = busy_q;
  assign bus.seq_done     = done_q;

endmodule
